// File: rtl/nrzi_tx_framer.sv
`default_nettype none
// ============================================================================
// Module   : nrzi_tx_framer
// Purpose  : Accepts a fixed-length frame of bytes over a valid/ready
//            handshake and serializes each byte LSB-first, one bit per
//            cycle. It drives the raw bit and enable for a downstream serial
//            CRC stage, plus the NRZI line level of the same bit stream
//            (a 0 toggles the line, a 1 holds it).
// Ports    : clk_i, rst_i        - clock, synchronous active-high reset
//            start_i             - begin a frame (sampled in IDLE only)
//            byte_i/byte_valid_i - frame byte and its valid flag
//            byte_ready_o        - combinational ready for byte_i
//            bit_o, bit_en_o     - registered serial bit and its strobe
//            nrzi_o              - registered NRZI line level
//            busy_o              - frame in progress (through done_o cycle)
//            done_o              - one-cycle end-of-frame pulse
// Revision : 1.0 - initial release
// ============================================================================
module nrzi_tx_framer #(
    parameter int   NUM_BYTES  = 4,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [7:0] byte_i,
    input  logic       byte_valid_i,
    output logic       byte_ready_o,
    output logic       bit_o,
    output logic       bit_en_o,
    output logic       nrzi_o,
    output logic       busy_o,
    output logic       done_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] C_LAST_BYTE = 4'(NUM_BYTES - 1);

    state_t     r_state;
    logic [3:0] r_byte_cnt;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shreg;
    logic       r_bit;
    logic       r_bit_en;
    logic       r_nrzi;
    logic       r_done;

    logic w_end_of_byte;
    logic w_last_byte;
    logic w_accept;

    assign w_end_of_byte = (r_state == S_SHIFT) && (r_bit_cnt == 3'd7);
    assign w_last_byte   = (r_byte_cnt == C_LAST_BYTE);

    // Ready in LOAD, and also on the final bit of a non-final byte so the
    // next byte can follow with no gap cycle.
    assign byte_ready_o = (r_state == S_LOAD) || (w_end_of_byte && !w_last_byte);
    assign w_accept     = byte_valid_i && byte_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_byte_cnt <= 4'd0;
            r_bit_cnt  <= 3'd0;
            r_shreg    <= 8'd0;
            r_bit      <= 1'b0;
            r_bit_en   <= 1'b0;
            r_nrzi     <= IDLE_LEVEL;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_bit_en <= 1'b0;
                    if (start_i) begin
                        r_nrzi     <= IDLE_LEVEL;
                        r_byte_cnt <= 4'd0;
                        r_state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_bit_en <= 1'b0;
                    if (w_accept) begin
                        r_shreg   <= byte_i;
                        r_bit_cnt <= 3'd0;
                        r_state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_bit     <= r_shreg[0];
                    r_bit_en  <= 1'b1;
                    if (!r_shreg[0]) begin
                        r_nrzi <= ~r_nrzi;
                    end
                    r_shreg   <= {1'b0, r_shreg[7:1]};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (w_end_of_byte) begin
                        if (w_last_byte) begin
                            r_state <= S_DONE;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 4'd1;
                            if (w_accept) begin
                                // Back-to-back byte: reload and keep shifting.
                                r_shreg   <= byte_i;
                                r_bit_cnt <= 3'd0;
                            end else begin
                                r_state <= S_LOAD;
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_done   <= 1'b1;
                    r_bit_en <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bit_o    = r_bit;
    assign bit_en_o = r_bit_en;
    assign nrzi_o   = r_nrzi;
    assign done_o   = r_done;
    // The done pulse lands after the state has returned to IDLE; keep busy
    // asserted through it so the frame window covers the done cycle.
    assign busy_o   = (r_state != S_IDLE) || r_done;

endmodule
`default_nettype wire

// File: tb/tb_nrzi_tx_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_nrzi_tx_framer
// Purpose  : Self-checking bench for nrzi_tx_framer. Table-driven frames,
//            hand-written reset sequences and random frames are compared
//            against a bit-level reference model of the serial/NRZI stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nrzi_tx_framer;

    localparam int   NB = 4;
    localparam logic IL = 1'b1;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       start_i = 1'b0;
    logic [7:0] byte_i = 8'h00;
    logic       byte_valid_i = 1'b0;
    logic       byte_ready_o;
    logic       bit_o;
    logic       bit_en_o;
    logic       nrzi_o;
    logic       busy_o;
    logic       done_o;

    nrzi_tx_framer #(
        .NUM_BYTES  (NB),
        .IDLE_LEVEL (IL)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .bit_o        (bit_o),
        .bit_en_o     (bit_en_o),
        .nrzi_o       (nrzi_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    // ---------------- monitor (samples mid-cycle on the falling edge) -------
    int   cyc       = 0;
    int   en_cnt    = 0;
    int   done_cnt  = 0;
    int   done_bad  = 0;
    int   busy_bad  = 0;
    logic prev_en   = 1'b0;
    logic mon_bit  [0:4095];
    logic mon_nrzi [0:4095];
    int   mon_cyc  [0:4095];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bit_en_o === 1'b1) begin
            mon_bit[en_cnt]  <= bit_o;
            mon_nrzi[en_cnt] <= nrzi_o;
            mon_cyc[en_cnt]  <= cyc;
            en_cnt           <= en_cnt + 1;
        end
        if (done_o === 1'b1) begin
            done_cnt <= done_cnt + 1;
            if (prev_en !== 1'b1) done_bad <= done_bad + 1;
        end
        if (((done_o === 1'b1) || (bit_en_o === 1'b1)) && (busy_o !== 1'b1))
            busy_bad <= busy_bad + 1;
        prev_en <= bit_en_o;
    end

    // ---------------- helpers ----------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte. 'stall' counts edges where the DUT is ready but valid
    // is held low before the byte is finally offered.
    task automatic send_byte(input logic [7:0] b, input int stall, input bit pulse, output logic ok);
        int   n;
        logic rdy;
        n  = 0;
        ok = 1'b0;
        byte_i = b;
        for (int t = 0; t < 200 && !ok; t++) begin
            byte_valid_i = (n >= stall);
            start_i      = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            rdy = byte_ready_o;
            tick();
            if (rdy === 1'b1) begin
                if (byte_valid_i) ok = 1'b1;
                else n++;
            end
        end
        byte_valid_i = 1'b0;
    endtask

    task automatic run_frame(input logic [31:0] data, input logic [15:0] stalls,
                             input bit pulse, input logic exp_final, input string tag);
        int          e0, d0, db0, bb0, gap, exp_gap;
        logic        ok, lvl;
        logic [31:0] got_bits, got_nrzi, exp_nrzi;
        e0 = en_cnt; d0 = done_cnt; db0 = done_bad; bb0 = busy_bad;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < NB; i++) begin
            send_byte(data[8*i +: 8], int'(stalls[4*i +: 4]), pulse, ok);
            if (!ok) check({tag, "_handshake_timeout"}, 32'(ok), 32'd1);
        end
        start_i = 1'b0;
        for (int t = 0; t < 60 && done_cnt == d0; t++) tick();
        tick();
        tick();

        // Reference: bits go out LSB-first byte 0 first, so the stream is
        // simply data[0..31]; the line flips on every 0 from IDLE level.
        lvl = IL;
        exp_gap = 0;
        for (int i = 0; i < 32; i++) begin
            if (!data[i]) lvl = ~lvl;
            exp_nrzi[i] = lvl;
        end
        for (int i = 1; i < NB; i++) exp_gap += int'(stalls[4*i +: 4]);

        for (int i = 0; i < 32; i++) begin
            got_bits[i] = mon_bit[e0 + i];
            got_nrzi[i] = mon_nrzi[e0 + i];
        end
        gap = (en_cnt - e0 == 32) ? (mon_cyc[e0 + 31] - mon_cyc[e0] - 31) : -1;

        check({tag, "_enables"},   32'(en_cnt - e0),  32'd32);
        check({tag, "_bits"},      got_bits,          data);
        check({tag, "_nrzi"},      got_nrzi,          exp_nrzi);
        check({tag, "_gap"},       32'(gap),          32'(exp_gap));
        check({tag, "_done_cnt"},  32'(done_cnt - d0), 32'd1);
        check({tag, "_done_time"}, 32'(done_bad - db0), 32'd0);
        check({tag, "_busy_win"},  32'(busy_bad - bb0), 32'd0);
        check({tag, "_final_lvl"}, 32'(nrzi_o),       32'(exp_final));
        check({tag, "_idle_busy"}, 32'(busy_o),       32'd0);
    endtask

    // ---------------- stimulus ---------------------------------------------
    typedef struct {
        logic [31:0] data;      // byte i in data[8i+:8]
        logic [15:0] stalls;    // stall for byte i in stalls[4i+:4]
        bit          pulse;     // toggle start_i randomly during the frame
        logic        exp_final; // line level after the last bit
    } vec_t;

    vec_t tbl [7];

    initial begin
        int          e0, d0;
        logic [31:0] rd;
        logic [15:0] rs;
        logic        fin;

        tbl[0] = '{32'h0000_00A5, 16'h0000, 1'b0, 1'b1}; // 0xA5 then zeros
        tbl[1] = '{32'hFF00_FF00, 16'h0000, 1'b0, 1'b1}; // 00,FF,00,FF
        tbl[2] = '{32'hFF00_FF00, 16'h5000, 1'b0, 1'b1}; // stall before byte 3
        tbl[3] = '{32'hFF00_FF00, 16'h0000, 1'b1, 1'b1}; // start pulses mid-frame
        tbl[4] = '{32'h7856_3412, 16'h0000, 1'b0, 1'b0}; // 12,34,56,78
        tbl[5] = '{32'hFFFF_FFFF, 16'h1111, 1'b0, 1'b1};
        tbl[6] = '{32'h0000_0001, 16'h0230, 1'b1, 1'b0};

        // Reset state
        tick(); tick();
        check("rst_bit_en", 32'(bit_en_o),     32'd0);
        check("rst_bit",    32'(bit_o),        32'd0);
        check("rst_done",   32'(done_o),       32'd0);
        check("rst_nrzi",   32'(nrzi_o),       32'(IL));
        check("rst_busy",   32'(busy_o),       32'd0);
        check("rst_ready",  32'(byte_ready_o), 32'd0);
        rst_i = 1'b0;
        tick();

        // Bytes offered in IDLE must not be taken
        byte_valid_i = 1'b1;
        byte_i = 8'h55;
        check("idle_ready", 32'(byte_ready_o), 32'd0);
        tick();
        check("idle_stays", 32'(busy_o), 32'd0);
        byte_valid_i = 1'b0;

        for (int i = 0; i < 7; i++)
            run_frame(tbl[i].data, tbl[i].stalls, tbl[i].pulse, tbl[i].exp_final,
                      $sformatf("vec%0d", i));

        // Reset mid-frame after bit 13
        e0 = en_cnt; d0 = done_cnt;
        byte_i = 8'h3C; byte_valid_i = 1'b1; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int t = 0; t < 100 && (en_cnt - e0) < 13; t++) tick();
        check("midrst_reached13", 32'(en_cnt - e0 >= 13), 32'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        byte_valid_i = 1'b0;
        check("midrst_busy",   32'(busy_o),       32'd0);
        check("midrst_nrzi",   32'(nrzi_o),       32'(IL));
        check("midrst_bit_en", 32'(bit_en_o),     32'd0);
        check("midrst_ready",  32'(byte_ready_o), 32'd0);
        check("midrst_done",   32'(done_o),       32'd0);
        tick(); tick(); tick();
        check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        run_frame(32'h7856_3412, 16'h0000, 1'b0, 1'b0, "after_rst");

        // Simultaneous reset and start: reset wins
        rst_i = 1'b1; start_i = 1'b1;
        tick();
        rst_i = 1'b0; start_i = 1'b0;
        check("rst_start_busy", 32'(busy_o), 32'd0);
        tick();
        check("rst_start_idle", 32'(busy_o), 32'd0);

        // Random frames
        for (int k = 0; k < 30; k++) begin
            rd = $urandom;
            rs = 16'h0000;
            for (int i = 0; i < NB; i++)
                if ($urandom_range(0, 1) == 1) rs[4*i +: 4] = 4'($urandom_range(1, 3));
            // Final level: IDLE_LEVEL flipped once per zero bit in the frame.
            fin = IL ^ 1'((32 - $countones(rd)) % 2);
            run_frame(rd, rs, 1'($urandom_range(0, 1)), fin, $sformatf("rnd%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
